// File: rtl/if_stage_with_if_id.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS pipe.
// Word-addressed instruction memory, hazard freeze, branch redirect with one-bubble flush.
module if_stage_with_if_id #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_target,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_instruction,
  output logic        IF_ID_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic        wr_in_range;
  logic        unused_bits;

  // Byte-offset bits of the load address and branch target carry no information.
  assign unused_bits = ^{imem_waddr[1:0], Br_target[1:0]};

  // Addresses beyond the memory fetch a NOP rather than aliasing.
  always_comb begin
    fetch_word = '0;
    if (pc_q[31:ADDR_W+2] == '0) fetch_word = imem[pc_q[ADDR_W+1:2]];
  end

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (!freeze) begin
      if (Br_taken) begin
        // Squash the wrong-path instruction already in IF/ID.
        pc_d          = {Br_target[31:2], 2'b00};
        if_id_pc_d    = '0;
        if_id_instr_d = '0;
        if_id_valid_d = 1'b0;
      end else begin
        pc_d          = pc_plus4;
        if_id_pc_d    = pc_plus4;
        if_id_instr_d = fetch_word;
        if_id_valid_d = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Memory survives reset so a program loaded during rst is still there afterwards.
  assign wr_in_range = (imem_waddr[31:ADDR_W+2] == '0);

  always_ff @(posedge clk) begin
    if (imem_we && wr_in_range) imem[imem_waddr[ADDR_W+1:2]] <= imem_wdata;
  end

  assign PC                = pc_q;
  assign IF_ID_PC          = if_id_pc_q;
  assign IF_ID_instruction = if_id_instr_q;
  assign IF_ID_valid       = if_id_valid_q;
  assign fetch_count       = fetch_count_q;

endmodule
